// File: rtl/fft_pkg.sv
// Shared types and defaults for the radix-2 FFT stage controller.
// Holds the FSM state encoding, parameter defaults and width helpers.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fft_state_e;

  localparam int N_LOG2_DEF  = 3;
  localparam int RD_LAT_DEF  = 1;
  localparam int TFM_LAT_DEF = 2;
  localparam int ADDR_W_DEF  = N_LOG2_DEF;

  // Width of the stage index for a given log2(N).
  function automatic int stage_w(input int n_log2);
    return (n_log2 < 2) ? 1 : $clog2(n_log2);
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address and twiddle index generator for
// counter k within stage s of an in-place radix-2 FFT.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF
) (
  input  logic [N_LOG2-2:0]         k,
  input  logic [$clog2(N_LOG2)-1:0] s,
  output logic [N_LOG2-1:0]         addr_a,
  output logic [N_LOG2-1:0]         addr_b,
  output logic [N_LOG2-2:0]         tw_idx
);

  localparam int SW = $clog2(N_LOG2);

  logic [N_LOG2-1:0] k_ext;
  logic [N_LOG2-1:0] half;
  logic [N_LOG2-1:0] pos;
  logic [N_LOG2-1:0] grp;
  logic [N_LOG2-1:0] tw_full;
  logic [SW-1:0]     tw_sh;

  // Split k into group/position; the group stride is two half-blocks.
  always_comb begin
    k_ext   = {1'b0, k};
    half    = N_LOG2'(1) << s;
    pos     = k_ext & (half - N_LOG2'(1));
    grp     = k_ext >> s;
    addr_a  = ((grp << s) << 1) | pos;
    addr_b  = addr_a + half;
    tw_sh   = SW'(N_LOG2 - 1) - s;
    tw_full = pos << tw_sh;
    tw_idx  = tw_full[N_LOG2-2:0];
  end

endmodule

// File: rtl/fft_stage_ctrl.sv
// Stage sequencer for an in-place radix-2 FFT: issues N/2 butterfly reads
// per stage, drains the read/multiply pipeline, and tracks write-back.
module fft_stage_ctrl
  import fft_pkg::*;
#(
  parameter int N_LOG2  = N_LOG2_DEF,
  parameter int RD_LAT  = RD_LAT_DEF,
  parameter int TFM_LAT = TFM_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(N_LOG2)-1:0] stage,
  output logic                      rd_en,
  output logic [N_LOG2-1:0]         rd_addr_a,
  output logic [N_LOG2-1:0]         rd_addr_b,
  output logic [N_LOG2-2:0]         tw_idx,
  output logic                      tfm_en,
  output logic                      wr_en,
  output logic [N_LOG2-1:0]         wr_addr_a,
  output logic [N_LOG2-1:0]         wr_addr_b
);

  localparam int SW     = $clog2(N_LOG2);
  localparam int KW     = N_LOG2 - 1;
  localparam int N_HALF = 2 ** (N_LOG2 - 1);
  localparam int DLY    = RD_LAT + TFM_LAT;
  localparam int DW     = (DLY > 1) ? $clog2(DLY) : 1;

  fft_state_e        state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [SW-1:0]     s_q, s_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;

  logic              pv_q [DLY];
  logic              pv_d [DLY];
  logic [N_LOG2-1:0] pa_q [DLY];
  logic [N_LOG2-1:0] pa_d [DLY];
  logic [N_LOG2-1:0] pb_q [DLY];
  logic [N_LOG2-1:0] pb_d [DLY];

  logic [N_LOG2-1:0] ag_a;
  logic [N_LOG2-1:0] ag_b;
  logic [N_LOG2-2:0] ag_tw;

  fft_addr_gen #(.N_LOG2(N_LOG2)) u_addr_gen (
    .k      (k_q),
    .s      (s_q),
    .addr_a (ag_a),
    .addr_b (ag_b),
    .tw_idx (ag_tw)
  );

  // State, butterfly counter, stage index and drain counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      s_q     <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Next-state logic; abort overrides everything, including start in IDLE.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    dcnt_d  = dcnt_q;
    if (abort) begin
      state_d = ST_IDLE;
      k_d     = '0;
      s_d     = '0;
      dcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_ISSUE;
            k_d     = '0;
            s_d     = '0;
            dcnt_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (k_q == KW'(N_HALF - 1)) begin
            state_d = ST_DRAIN;
            k_d     = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        ST_DRAIN: begin
          // Full pipeline depth elapses so the last write precedes the next read.
          if (dcnt_q == DW'(DLY - 1)) begin
            dcnt_d = '0;
            if (s_q == SW'(N_LOG2 - 1)) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_ISSUE;
              s_d     = s_q + SW'(1);
            end
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          s_d     = '0;
        end
        default: begin
          state_d = ST_IDLE;
          k_d     = '0;
          s_d     = '0;
          dcnt_d  = '0;
        end
      endcase
    end
  end

  assign rd_en = (state_q == ST_ISSUE);
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign stage = s_q;

  // Addresses are held at zero whenever no read is issued.
  always_comb begin
    if (rd_en) begin
      rd_addr_a = ag_a;
      rd_addr_b = ag_b;
      tw_idx    = ag_tw;
    end else begin
      rd_addr_a = '0;
      rd_addr_b = '0;
      tw_idx    = '0;
    end
  end

  // Read/multiply pipeline tracking: valid bit plus operand addresses.
  always_comb begin
    pv_d[0] = rd_en;
    pa_d[0] = rd_addr_a;
    pb_d[0] = rd_addr_b;
    for (int i = 1; i < DLY; i++) begin
      pv_d[i] = pv_q[i-1];
      pa_d[i] = pa_q[i-1];
      pb_d[i] = pb_q[i-1];
    end
    if (abort) begin
      for (int i = 0; i < DLY; i++) begin
        pv_d[i] = 1'b0;
        pa_d[i] = '0;
        pb_d[i] = '0;
      end
    end else begin
      pv_d[0] = rd_en;
    end
  end

  // Delay-line registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DLY; i++) begin
        pv_q[i] <= 1'b0;
        pa_q[i] <= '0;
        pb_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DLY; i++) begin
        pv_q[i] <= pv_d[i];
        pa_q[i] <= pa_d[i];
        pb_q[i] <= pb_d[i];
      end
    end
  end

  assign tfm_en    = pv_q[RD_LAT-1];
  assign wr_en     = pv_q[DLY-1];
  assign wr_addr_a = pa_q[DLY-1];
  assign wr_addr_b = pb_q[DLY-1];

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Self-checking bench for fft_stage_ctrl: directed scenarios plus random
// start/abort/reset traffic against a cycle-count reference model.
module tb_fft_stage_ctrl;

  localparam int N_LOG2  = 3;
  localparam int RD_LAT  = 1;
  localparam int TFM_LAT = 2;
  localparam int NH      = 2 ** (N_LOG2 - 1);
  localparam int D       = RD_LAT + TFM_LAT;
  localparam int P       = NH + D;
  localparam int T_DONE  = N_LOG2 * P + 1;

  logic                      clk;
  logic                      rst;
  logic                      start;
  logic                      abort;
  logic                      busy;
  logic                      done;
  logic [$clog2(N_LOG2)-1:0] stage;
  logic                      rd_en;
  logic [N_LOG2-1:0]         rd_addr_a;
  logic [N_LOG2-1:0]         rd_addr_b;
  logic [N_LOG2-2:0]         tw_idx;
  logic                      tfm_en;
  logic                      wr_en;
  logic [N_LOG2-1:0]         wr_addr_a;
  logic [N_LOG2-1:0]         wr_addr_b;

  fft_stage_ctrl #(.N_LOG2(N_LOG2), .RD_LAT(RD_LAT), .TFM_LAT(TFM_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .stage     (stage),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_idx    (tw_idx),
    .tfm_en    (tfm_en),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: m_t counts cycles since the start-sampling edge (first ISSUE = 1).
  bit m_run;
  int m_t;
  int hv [D];
  int ha [D];
  int hb [D];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_run = 1'b0;
    m_t   = 0;
    for (int i = 0; i < D; i++) begin
      hv[i] = 0;
      ha[i] = 0;
      hb[i] = 0;
    end
  endtask

  task automatic exp_rd(output int en, output int a, output int b, output int tw);
    int off, s, k, half;
    en = 0; a = 0; b = 0; tw = 0;
    if (m_run && m_t < T_DONE) begin
      off = (m_t - 1) % P;
      s   = (m_t - 1) / P;
      if (off < NH) begin
        k    = off;
        half = 2 ** s;
        en   = 1;
        a    = (k / half) * 2 * half + (k % half);
        b    = a + half;
        tw   = (k % half) * (2 ** (N_LOG2 - 1 - s));
      end
    end
  endtask

  task automatic check_outputs();
    int en, a, b, tw, stg;
    exp_rd(en, a, b, tw);
    stg = !m_run ? 0 : (m_t == T_DONE ? N_LOG2 - 1 : (m_t - 1) / P);
    check_val("busy", busy, m_run);
    check_val("done", done, (m_run && m_t == T_DONE) ? 1 : 0);
    check_val("stage", stage, stg);
    check_val("rd_en", rd_en, en);
    check_val("rd_addr_a", rd_addr_a, a);
    check_val("rd_addr_b", rd_addr_b, b);
    check_val("tw_idx", tw_idx, tw);
    check_val("tfm_en", tfm_en, hv[RD_LAT-1]);
    check_val("wr_en", wr_en, hv[D-1]);
    check_val("wr_addr_a", wr_addr_a, ha[D-1]);
    check_val("wr_addr_b", wr_addr_b, hb[D-1]);
  endtask

  task automatic model_edge();
    int en, a, b, tw;
    exp_rd(en, a, b, tw);
    if (!rst) begin
      model_clear();
    end else begin
      for (int i = D - 1; i > 0; i--) begin
        hv[i] = hv[i-1];
        ha[i] = ha[i-1];
        hb[i] = hb[i-1];
      end
      hv[0] = en;
      ha[0] = a;
      hb[0] = b;
      if (abort) begin
        model_clear();
      end else if (m_run) begin
        if (m_t == T_DONE) m_run = 1'b0;
        else m_t++;
      end else if (start) begin
        m_run = 1'b1;
        m_t   = 1;
      end
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check 1ns later, step model at the rising edge.
  task automatic do_cycle(input bit st, input bit ab, input bit rn);
    @(negedge clk);
    start = st;
    abort = ab;
    rst   = rn;
    if (!rn) model_clear();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
  endtask

  initial begin
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    model_clear();

    repeat (2) do_cycle(1'b0, 1'b0, 1'b0);
    repeat (3) do_cycle(1'b0, 1'b0, 1'b1);

    // Plain full transform.
    do_cycle(1'b1, 1'b0, 1'b1);
    repeat (27) do_cycle(1'b0, 1'b0, 1'b1);

    // Abort at cycle 10 of a run.
    do_cycle(1'b1, 1'b0, 1'b1);
    repeat (9) do_cycle(1'b0, 1'b0, 1'b1);
    do_cycle(1'b0, 1'b1, 1'b1);
    repeat (15) do_cycle(1'b0, 1'b0, 1'b1);

    // Abort and start together in IDLE.
    do_cycle(1'b1, 1'b1, 1'b1);
    repeat (3) do_cycle(1'b0, 1'b0, 1'b1);

    // Reset pulsed in the stage-1 drain window.
    do_cycle(1'b1, 1'b0, 1'b1);
    repeat (12) do_cycle(1'b0, 1'b0, 1'b1);
    do_cycle(1'b0, 1'b0, 1'b0);
    repeat (20) do_cycle(1'b0, 1'b0, 1'b1);

    // Start held high across consecutive transforms.
    repeat (70) do_cycle(1'b1, 1'b0, 1'b1);
    repeat (5) do_cycle(1'b0, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      do_cycle(1'($urandom_range(0, 1)),
               ($urandom_range(0, 49) == 0),
               ($urandom_range(0, 299) != 0));
    end
    repeat (30) do_cycle(1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fft_stage_ctrl.md
FFT_STAGE_CTRL -- requirements
Module: fft_stage_ctrl

Interface
REQ-001 The module SHALL have these parameters: N_LOG2, default 3, log2 of FFT points (N = 2^N_LOG2, N_LOG2 >= 2).
REQ-002 The module SHALL have these parameters: RD_LAT, default 1, sample-buffer read latency in cycles.
REQ-003 The module SHALL have these parameters: TFM_LAT, default 2, twiddle-multiplier latency in cycles.
REQ-004 The module SHALL have these ports:
  clk  in  1  clock, rising edge.
  rst  in  1  asynchronous, active-low reset.
  start  in  1  begin a full N-point transform; sampled only in IDLE.
  abort  in  1  synchronous cancel of the running transform.
  busy  out  1  high in ISSUE/DRAIN/DONE.
  done  out  1  one-cycle pulse on transform completion.
  stage  out  clog2(N_LOG2)  current stage index s.
  rd_en  out  1  buffer read strobe for one butterfly pair.
  rd_addr_a, rd_addr_b  out  N_LOG2  butterfly operand addresses.
  tw_idx  out  N_LOG2-1  twiddle ROM index, aligned with rd_en.
  tfm_en  out  1  multiplier enable, equal to rd_en delayed RD_LAT cycles.
  wr_en  out  1  write-back strobe, equal to rd_en delayed RD_LAT+TFM_LAT cycles.
  wr_addr_a, wr_addr_b  out  N_LOG2  rd addresses delayed RD_LAT+TFM_LAT cycles.

Function
REQ-005 The FSM SHALL have the states IDLE, ISSUE, DRAIN and DONE.
REQ-006 The FSM SHALL take these transitions:
  IDLE->ISSUE on start.
  ISSUE->DRAIN after N/2 issues.
  DRAIN->ISSUE (next stage) after RD_LAT+TFM_LAT cycles when s < N_LOG2-1, otherwise DRAIN->DONE.
  DONE->IDLE unconditionally.
REQ-007 In ISSUE, rd_en SHALL be 1 every cycle, with butterfly counter k running 0..N/2-1 with no gaps.
REQ-008 rd_en SHALL be 0 in all other states.
REQ-009 Addressing SHALL be computed as follows, with half = 2^s:
  pos = k mod half.
  grp = k >> s.
  rd_addr_a = grp*2*half + pos.
  rd_addr_b = rd_addr_a + half.
  tw_idx = pos << (N_LOG2-1-s).
REQ-010 k SHALL wrap to 0 and s SHALL increment on the DRAIN->ISSUE transition.
REQ-011 s SHALL reset to 0 on the IDLE->ISSUE transition.
REQ-012 DRAIN SHALL guarantee that the last write of stage s occurs before the first read of stage s+1, so there is no read-after-write hazard.
REQ-013 done SHALL be 1 only in DONE.
REQ-014 done SHALL be asserted exactly N_LOG2*(N/2+RD_LAT+TFM_LAT)+1 cycles after the start-sampling edge.
REQ-015 start SHALL be ignored outside IDLE, including in the DONE cycle.
REQ-016 abort SHALL force IDLE on the next edge from any state.
REQ-017 abort SHALL clear the delay lines, so no tfm_en or wr_en pulse occurs after that edge.
REQ-018 done SHALL NOT be pulsed on abort.
REQ-019 abort in IDLE SHALL have no effect.
REQ-020 When abort and start are high simultaneously in IDLE, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-021 The delay lines SHALL be shift registers of valid bits plus addresses, with no back-pressure; every issued pair SHALL produce exactly one wr_en.

Reset
REQ-022 On rst low, state SHALL go to IDLE, and k, s and all delay-line stages SHALL be cleared to 0.
REQ-023 All outputs SHALL be 0 during reset and in IDLE.
REQ-024 Reset mid-transform SHALL discard all in-flight writes.
REQ-025 Deassertion of rst SHALL NOT by itself start a transform.

Structure
REQ-026 Shared package fft_pkg SHALL hold the FSM state enum, the N_LOG2/RD_LAT/TFM_LAT defaults, and an address-width helper constant.
REQ-027 The sub-module fft_addr_gen SHALL be purely combinational, taking (k, s) and producing (rd_addr_a, rd_addr_b, tw_idx).
REQ-028 The FSM, counters and delay lines SHALL reside in fft_stage_ctrl.

Verification
REQ-029 N_LOG2=3, start pulse at cycle 0: rd_en SHALL be high in cycles 1-4, 8-11 and 15-18, and done SHALL be high in cycle 22 only.
REQ-030 Stage 0 (N=8): (a,b,tw) SHALL be (0,1,0),(2,3,0),(4,5,0),(6,7,0).
REQ-031 Stage 1 (N=8): (a,b,tw) SHALL be (0,2,0),(1,3,2),(4,6,0),(5,7,2).
REQ-032 Stage 2 (N=8): (a,b,tw) SHALL be (0,4,0),(1,5,1),(2,6,2),(3,7,3).
REQ-033 wr_en/wr_addr SHALL trail rd_en/rd_addr by exactly 3 cycles, and tfm_en SHALL trail rd_en by exactly 1 cycle.
REQ-034 abort asserted at cycle 10 of an N=8 run: IDLE SHALL be reached at cycle 11, with zero wr_en after cycle 11 and no done.
REQ-035 start held high continuously: done SHALL be followed by IDLE for one cycle, then a new ISSUE, with no start accepted in DONE.
REQ-036 rst pulsed low in DRAIN of stage 1: all outputs SHALL be 0 immediately, there SHALL be no further wr_en, and the block SHALL stay idle until the next start.
